// File: rtl/clk_fail_monitor_if.sv
// Request/status bundle between the clkB failover controller and its requester.
// The slave side is the controller; the master side drives the requests.
interface clk_fail_monitor_if #(
  parameter int unsigned CW = 7
);
  logic          prefer_b;
  logic          force_a;
  logic          select;
  logic          clkb_ok;
  logic [CW-1:0] win_count;
  logic          fail;
  logic [1:0]    state;

  modport master (
    output prefer_b, force_a,
    input  select, clkb_ok, win_count, fail, state
  );

  modport slave (
    input  prefer_b, force_a,
    output select, clkb_ok, win_count, fail, state
  );
endinterface

// File: rtl/clk_fail_monitor.sv
// Qualifies clkB by counting its edges over fixed clkA windows and drives the
// glitch-free switch select, falling back to clkA on drift, loss, force or release.
module clk_fail_monitor #(
  parameter int unsigned WIN_CYCLES   = 256,
  parameter int unsigned MIN_EDGES    = 60,
  parameter int unsigned MAX_EDGES    = 68,
  parameter int unsigned GOOD_WINDOWS = 4,
  parameter int unsigned BAD_WINDOWS  = 1,
  parameter int unsigned HOLDOFF      = 16
) (
  input  logic               clkA,
  input  logic               rst,
  input  logic               clkB,
  clk_fail_monitor_if.slave  mon
);
  localparam int unsigned CW = $clog2(MAX_EDGES + 2);
  localparam int unsigned WW = $clog2(WIN_CYCLES);
  localparam int unsigned GW = $clog2(GOOD_WINDOWS + 1);
  localparam int unsigned BW = $clog2(BAD_WINDOWS + 1);
  localparam int unsigned HW = $clog2(HOLDOFF + 1);

  localparam logic [WW-1:0] WinLast  = WW'(WIN_CYCLES - 1);
  localparam logic [CW-1:0] EdgeSat  = CW'(MAX_EDGES + 1);
  localparam logic [CW-1:0] EdgeMin  = CW'(MIN_EDGES);
  localparam logic [CW-1:0] EdgeMax  = CW'(MAX_EDGES);
  localparam logic [GW-1:0] GoodMax  = GW'(GOOD_WINDOWS);
  localparam logic [BW-1:0] BadMax   = BW'(BAD_WINDOWS);
  localparam logic [HW-1:0] HoldLast = HW'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    StA     = 2'd0,
    StHoldB = 2'd1,
    StB     = 2'd2,
    StHoldA = 2'd3
  } state_e;

  // clkB-domain toggle; its level carries each clkB posedge across to clkA.
  logic tog_q;
  always_ff @(posedge clkB) begin
    tog_q <= ~tog_q;
  end

  logic [2:0] sync_q;
  logic       clkb_edge;

  always_ff @(posedge clkA) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], tog_q};
  end

  assign clkb_edge = sync_q[1] ^ sync_q[2];

  // Window measurement
  logic [WW-1:0] wcnt_q;
  logic [CW-1:0] ecnt_q, ecnt_inc, win_count_q;
  logic          win_good_q, win_done_q, first_q, terminal;
  logic [GW-1:0] good_run_q;
  logic [BW-1:0] bad_run_q;

  always_comb begin
    terminal = (wcnt_q == WinLast);
    ecnt_inc = ecnt_q;
    if (clkb_edge && (ecnt_q != EdgeSat)) ecnt_inc = ecnt_q + 1'b1;
  end

  always_ff @(posedge clkA) begin
    if (rst) begin
      wcnt_q      <= '0;
      ecnt_q      <= '0;
      win_count_q <= '0;
      win_good_q  <= 1'b0;
      win_done_q  <= 1'b0;
      first_q     <= 1'b1;
      good_run_q  <= '0;
      bad_run_q   <= '0;
    end else begin
      wcnt_q     <= terminal ? '0 : wcnt_q + 1'b1;
      win_done_q <= terminal;
      if (terminal) begin
        ecnt_q      <= '0;
        win_count_q <= ecnt_inc;
        win_good_q  <= (ecnt_inc >= EdgeMin) && (ecnt_inc <= EdgeMax);
      end else begin
        ecnt_q <= ecnt_inc;
      end
      // The first window after reset started with an unknown synchronizer history.
      if (win_done_q) begin
        if (first_q) begin
          first_q <= 1'b0;
        end else if (win_good_q) begin
          good_run_q <= (good_run_q == GoodMax) ? GoodMax : good_run_q + 1'b1;
          bad_run_q  <= '0;
        end else begin
          bad_run_q  <= (bad_run_q == BadMax) ? BadMax : bad_run_q + 1'b1;
          good_run_q <= '0;
        end
      end
    end
  end

  // Select FSM
  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          select_q, select_d, fail_q, fail_d;
  logic          good_hit, bad_hit, hold_done;

  always_comb begin
    good_hit  = (good_run_q == GoodMax);
    bad_hit   = (bad_run_q == BadMax);
    hold_done = (hcnt_q == HoldLast);
    state_d   = state_q;
    fail_d    = 1'b0;
    unique case (state_q)
      StA: begin
        if (mon.prefer_b && !mon.force_a && good_hit) state_d = StHoldB;
      end
      StHoldB: begin
        if (mon.force_a || bad_hit) begin
          state_d = StHoldA;
          fail_d  = bad_hit;
        end else if (hold_done) begin
          state_d = StB;
        end
      end
      StB: begin
        if (bad_hit || mon.force_a || !mon.prefer_b) begin
          state_d = StHoldA;
          fail_d  = bad_hit;
        end
      end
      StHoldA: begin
        if (hold_done) state_d = StA;
      end
      default: state_d = StA;
    endcase

    hcnt_d = '0;
    if ((state_d == state_q) && ((state_q == StHoldB) || (state_q == StHoldA))) begin
      hcnt_d = hcnt_q + 1'b1;
    end
    select_d = (state_d == StA) || (state_d == StHoldA);
  end

  always_ff @(posedge clkA) begin
    if (rst) begin
      state_q  <= StA;
      hcnt_q   <= '0;
      select_q <= 1'b1;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      select_q <= select_d;
      fail_q   <= fail_d;
    end
  end

  assign mon.select    = select_q;
  assign mon.fail      = fail_q;
  assign mon.state     = state_q;
  assign mon.clkb_ok   = good_hit;
  assign mon.win_count = win_count_q;

endmodule
